// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default sizing for the pulse stretcher block.
package pulse_stretcher_pkg;

   localparam int DEFAULT_WIDTH_W = 8;
   localparam int DEFAULT_CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      HOLDOFF = 2'd2
   } state_e;

endpackage

// File: rtl/pulse_stretcher_timer.sv
// Loadable down-counter shared by the ACTIVE and HOLDOFF phases.
// done is high while the count is on its final cycle (1) or empty (0),
// so a load of N keeps the owning phase alive for exactly N cycles.
module pulse_stretcher_timer #(
   parameter int WIDTH_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [WIDTH_W-1:0] load_val,
   output logic               done
);

   localparam logic [WIDTH_W-1:0] CNT_ONE = WIDTH_W'(1);

   logic [WIDTH_W-1:0] cnt_q;
   logic [WIDTH_W-1:0] cnt_d;

   // Next count: a load wins, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Count register, cleared by reset so an aborted event leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q <= CNT_ONE);

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle input pulses into registered pulses of
// a programmable width followed by a programmable dead time, counting
// accepted and rejected pulses with saturating counters.
// Optional feature macro: PULSE_STRETCHER_RETRIGGER_EN -- when defined, a
// pulse during the stretch restarts the stretch instead of being a miss.
module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int WIDTH_W = DEFAULT_WIDTH_W,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               pulse_in,
   input  logic [WIDTH_W-1:0] width,
   input  logic [WIDTH_W-1:0] holdoff,
   output logic               stretch_out,
   output logic               busy,
   output logic [CNT_W-1:0]   pulse_count,
   output logic [CNT_W-1:0]   miss_count
);

   localparam logic [WIDTH_W-1:0] WIDTH_ONE = WIDTH_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   state_e             state_q;
   state_e             state_d;
   logic               stretch_q;
   logic               stretch_d;
   logic [WIDTH_W-1:0] holdoff_q;
   logic [WIDTH_W-1:0] holdoff_d;
   logic [CNT_W-1:0]   pulse_count_q;
   logic [CNT_W-1:0]   pulse_count_d;
   logic [CNT_W-1:0]   miss_count_q;
   logic [CNT_W-1:0]   miss_count_d;

   logic               timer_load;
   logic [WIDTH_W-1:0] timer_val;
   logic               timer_done;
   logic               accept;
   logic               retrig;
   logic               inc_pulse;
   logic               inc_miss;
   logic [WIDTH_W-1:0] accept_width;

   // A zero width still produces a one-cycle stretch.
   assign accept_width = (width == '0) ? WIDTH_ONE : width;
   assign accept       = enable && pulse_in;

   // Whether a pulse during the stretch restarts it (feature build) or is a miss.
   always_comb begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
      retrig = enable && pulse_in;
`else
      retrig = 1'b0;
`endif
   end

   pulse_stretcher_timer #(
      .WIDTH_W (WIDTH_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   // Next-state, timer control and counter updates for the three-phase event.
   always_comb begin
      state_d    = state_q;
      stretch_d  = stretch_q;
      holdoff_d  = holdoff_q;
      timer_load = 1'b0;
      timer_val  = accept_width;
      inc_pulse  = 1'b0;
      inc_miss   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = ACTIVE;
               stretch_d  = 1'b1;
               timer_load = 1'b1;
               holdoff_d  = holdoff;
               inc_pulse  = 1'b1;
            end
         end

         ACTIVE: begin
            if (retrig) begin
               timer_load = 1'b1;
               inc_pulse  = 1'b1;
            end else if (timer_done) begin
               if (holdoff_q == '0) begin
                  if (accept) begin
                     timer_load = 1'b1;
                     holdoff_d  = holdoff;
                     inc_pulse  = 1'b1;
                  end else begin
                     state_d   = IDLE;
                     stretch_d = 1'b0;
                  end
               end else begin
                  state_d    = HOLDOFF;
                  stretch_d  = 1'b0;
                  timer_load = 1'b1;
                  timer_val  = holdoff_q;
                  inc_miss   = pulse_in;
               end
            end else begin
               inc_miss = pulse_in;
            end
         end

         HOLDOFF: begin
            if (timer_done) begin
               if (accept) begin
                  state_d    = ACTIVE;
                  stretch_d  = 1'b1;
                  timer_load = 1'b1;
                  holdoff_d  = holdoff;
                  inc_pulse  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               inc_miss = pulse_in;
            end
         end

         default: begin
            state_d   = IDLE;
            stretch_d = 1'b0;
         end
      endcase

      pulse_count_d = pulse_count_q;
      if (inc_pulse && (pulse_count_q != CNT_MAX)) begin
         pulse_count_d = pulse_count_q + CNT_ONE;
      end

      miss_count_d = miss_count_q;
      if (inc_miss && (miss_count_q != CNT_MAX)) begin
         miss_count_d = miss_count_q + CNT_ONE;
      end
   end

   // State, output and counter registers; reset aborts any event in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         stretch_q     <= 1'b0;
         holdoff_q     <= '0;
         pulse_count_q <= '0;
         miss_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         stretch_q     <= stretch_d;
         holdoff_q     <= holdoff_d;
         pulse_count_q <= pulse_count_d;
         miss_count_q  <= miss_count_d;
      end
   end

   assign stretch_out = stretch_q;
   assign busy        = (state_q != IDLE);
   assign pulse_count = pulse_count_q;
   assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed testbench for pulse_stretcher; a second instance with 2-bit
// counters shares the stimulus to exercise counter saturation.
module tb_pulse_stretcher;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        pulse_in;
   logic [7:0]  width;
   logic [7:0]  holdoff;
   logic        stretch_out;
   logic        busy;
   logic [15:0] pulse_count;
   logic [15:0] miss_count;
   logic        sat_stretch_out;
   logic        sat_busy;
   logic [1:0]  sat_pulse_count;
   logic [1:0]  sat_miss_count;

   int checks;
   int failures;

   pulse_stretcher #(.WIDTH_W(8), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pulse_in    (pulse_in),
      .width       (width),
      .holdoff     (holdoff),
      .stretch_out (stretch_out),
      .busy        (busy),
      .pulse_count (pulse_count),
      .miss_count  (miss_count)
   );

   pulse_stretcher #(.WIDTH_W(8), .CNT_W(2)) dut_sat (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pulse_in    (pulse_in),
      .width       (width),
      .holdoff     (holdoff),
      .stretch_out (sat_stretch_out),
      .busy        (sat_busy),
      .pulse_count (sat_pulse_count),
      .miss_count  (sat_miss_count)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a single-cycle pulse that the next edge samples.
   task automatic applyStimulus();
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
   endtask

   // Count consecutive high cycles of stretch_out, optionally injecting a
   // pulse during the given high cycle (0 = never).
   task automatic count_high(input int inject_at, output int n);
      n = 0;
      while (stretch_out && n < 60) begin
         n++;
         if (n == inject_at) pulse_in = 1'b1;
         tick();
         pulse_in = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      enable   = 1'b1;
      pulse_in = 1'b0;
      width    = 8'd0;
      holdoff  = 8'd0;
      tick();
      tick();
      checks += 4;
      if (stretch_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_stretch got=%b want=0", stretch_out); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      if (pulse_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_pulse_count got=%0d want=0", pulse_count); end
      if (miss_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_miss_count got=%0d want=0", miss_count); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int n;
      do_reset();
      width   = 8'd4;
      holdoff = 8'd0;
      applyStimulus();
      width   = 8'd9;
      holdoff = 8'd7;
      count_high(0, n);
      checks += 4;
      if (n != 4) begin failures++; $display("[TB] FAIL basic_high_cycles got=%0d want=4", n); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after got=%b want=0", busy); end
      if (pulse_count !== 16'd1) begin failures++; $display("[TB] FAIL basic_pulse_count got=%0d want=1", pulse_count); end
      if (miss_count !== 16'd0) begin failures++; $display("[TB] FAIL basic_miss_count got=%0d want=0", miss_count); end
   endtask

   task automatic test_holdoff_miss();
      int n;
      int idle_wait;
      logic saw_high;
      do_reset();
      width   = 8'd3;
      holdoff = 8'd5;
      applyStimulus();
      count_high(0, n);
      checks += 2;
      if (n != 3) begin failures++; $display("[TB] FAIL holdoff_high_cycles got=%0d want=3", n); end
      if (busy !== 1'b1) begin failures++; $display("[TB] FAIL holdoff_busy got=%b want=1", busy); end
      tick();
      applyStimulus();
      checks += 1;
      if (miss_count !== 16'd1) begin failures++; $display("[TB] FAIL holdoff_miss_count got=%0d want=1", miss_count); end
      idle_wait = 0;
      saw_high  = 1'b0;
      while (busy && idle_wait < 60) begin
         if (stretch_out) saw_high = 1'b1;
         tick();
         idle_wait++;
      end
      checks += 3;
      if (idle_wait != 3) begin failures++; $display("[TB] FAIL holdoff_remaining got=%0d want=3", idle_wait); end
      if (saw_high !== 1'b0) begin failures++; $display("[TB] FAIL holdoff_no_stretch got=%b want=0", saw_high); end
      if (pulse_count !== 16'd1) begin failures++; $display("[TB] FAIL holdoff_pulse_count got=%0d want=1", pulse_count); end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      width   = 8'd2;
      holdoff = 8'd2;
      applyStimulus();
      count_high(0, n);
      tick();
      checks += 2;
      if (n != 2) begin failures++; $display("[TB] FAIL b2b_first_high got=%0d want=2", n); end
      if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_last_holdoff_busy got=%b want=1", busy); end
      applyStimulus();
      checks += 1;
      if (stretch_out !== 1'b1) begin failures++; $display("[TB] FAIL b2b_immediate got=%b want=1", stretch_out); end
      count_high(0, n);
      checks += 3;
      if (n != 2) begin failures++; $display("[TB] FAIL b2b_second_high got=%0d want=2", n); end
      if (pulse_count !== 16'd2) begin failures++; $display("[TB] FAIL b2b_pulse_count got=%0d want=2", pulse_count); end
      if (miss_count !== 16'd0) begin failures++; $display("[TB] FAIL b2b_miss_count got=%0d want=0", miss_count); end
   endtask

   task automatic test_width_zero_enable();
      int n;
      do_reset();
      width   = 8'd0;
      holdoff = 8'd0;
      applyStimulus();
      count_high(0, n);
      checks += 2;
      if (n != 1) begin failures++; $display("[TB] FAIL w0_high_cycles got=%0d want=1", n); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL w0_busy_after got=%b want=0", busy); end
      tick();
      enable = 1'b0;
      width  = 8'd3;
      applyStimulus();
      checks += 4;
      if (stretch_out !== 1'b0) begin failures++; $display("[TB] FAIL dis_stretch got=%b want=0", stretch_out); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL dis_busy got=%b want=0", busy); end
      if (pulse_count !== 16'd1) begin failures++; $display("[TB] FAIL dis_pulse_count got=%0d want=1", pulse_count); end
      if (miss_count !== 16'd0) begin failures++; $display("[TB] FAIL dis_miss_count got=%0d want=0", miss_count); end
      enable = 1'b1;
   endtask

   task automatic test_retrigger();
      int n;
      do_reset();
      width   = 8'd5;
      holdoff = 8'd0;
      applyStimulus();
      count_high(3, n);
      checks += 3;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
      if (n != 8) begin failures++; $display("[TB] FAIL retrig_high_cycles got=%0d want=8", n); end
      if (pulse_count !== 16'd2) begin failures++; $display("[TB] FAIL retrig_pulse_count got=%0d want=2", pulse_count); end
      if (miss_count !== 16'd0) begin failures++; $display("[TB] FAIL retrig_miss_count got=%0d want=0", miss_count); end
`else
      if (n != 5) begin failures++; $display("[TB] FAIL retrig_high_cycles got=%0d want=5", n); end
      if (pulse_count !== 16'd1) begin failures++; $display("[TB] FAIL retrig_pulse_count got=%0d want=1", pulse_count); end
      if (miss_count !== 16'd1) begin failures++; $display("[TB] FAIL retrig_miss_count got=%0d want=1", miss_count); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      width   = 8'd6;
      holdoff = 8'd3;
      applyStimulus();
      tick();
      checks += 1;
      if (stretch_out !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre_stretch got=%b want=1", stretch_out); end
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (stretch_out !== 1'b0) begin failures++; $display("[TB] FAIL midrst_stretch got=%b want=0", stretch_out); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
      if (pulse_count !== 16'd0) begin failures++; $display("[TB] FAIL midrst_pulse_count got=%0d want=0", pulse_count); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      width   = 8'd1;
      holdoff = 8'd0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         tick();
         tick();
      end
      checks += 3;
      if (pulse_count !== 16'd5) begin failures++; $display("[TB] FAIL sat_wide_count got=%0d want=5", pulse_count); end
      if (sat_pulse_count !== 2'd3) begin failures++; $display("[TB] FAIL sat_narrow_count got=%0d want=3", sat_pulse_count); end
      if (sat_busy !== 1'b0) begin failures++; $display("[TB] FAIL sat_busy got=%b want=0", sat_busy); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      enable   = 1'b1;
      pulse_in = 1'b0;
      width    = 8'd0;
      holdoff  = 8'd0;
      test_reset();
      test_basic();
      test_holdoff_miss();
      test_back_to_back();
      test_width_zero_enable();
      test_retrigger();
      test_reset_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
